// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator: solid, colour bars, checkerboard, gradient.
// Define PATTERN_SCROLL_EN to scroll the bar and checker patterns left one pixel per frame.
module vga_pattern_gen #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 56,
   parameter int H_SYNC     = 120,
   parameter int H_BP       = 64,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 37,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 23,
   parameter int H_SYNC_POL = 1,
   parameter int V_SYNC_POL = 1,
   parameter int CNT_W      = 11,
   parameter int COLOR_W    = 2,
   parameter int CHECK_LOG2 = 5,
   parameter int FRAME_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode_i,
   input  logic [3*COLOR_W-1:0]   solid_rgb_i,
   output logic [COLOR_W-1:0]     red_port,
   output logic [COLOR_W-1:0]     green_port,
   output logic [COLOR_W-1:0]     blue_port,
   output logic                   h_sync_in,
   output logic                   v_sync_in,
   output logic                   de_o,
   output logic [CNT_W-1:0]       h_count,
   output logic [CNT_W-1:0]       v_count,
   output logic                   frame_start_o,
   output logic [FRAME_W-1:0]     frame_count_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int GW      = CNT_W + COLOR_W;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BAR_W   = CNT_W'(H_ACTIVE / 8);
   localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(7);
   localparam logic             H_POL   = 1'(H_SYNC_POL);
   localparam logic             V_POL   = 1'(V_SYNC_POL);

   logic [CNT_W-1:0]     r_hc;
   logic [CNT_W-1:0]     r_vc;
   logic [1:0]           r_mode;
   logic [3*COLOR_W-1:0] r_solid;

   logic                 w_frameStart;
   logic [1:0]           w_mode;
   logic [3*COLOR_W-1:0] w_solid;
   logic [FRAME_W-1:0]   w_frameNext;
   logic                 w_de;
   logic                 w_hSync;
   logic                 w_vSync;
   logic [CNT_W-1:0]     w_x;
   logic [CNT_W-1:0]     w_barRaw;
   logic [2:0]           w_barIdx;
   logic                 w_checker;
   logic [COLOR_W-1:0]   w_gradR;
   logic [COLOR_W-1:0]   w_gradG;
   logic [3*COLOR_W-1:0] w_rgb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (r_hc == H_LAST) begin
         r_hc <= '0;
         r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
      end else begin
         r_hc <= r_hc + 1'b1;
      end
   end

   // The frame-start pixel already uses the freshly sampled mode/colour, so switches land cleanly on (0,0).
   assign w_frameStart = (r_hc == '0) && (r_vc == '0);
   assign w_mode       = w_frameStart ? mode_i : r_mode;
   assign w_solid      = w_frameStart ? solid_rgb_i : r_solid;
   assign w_frameNext  = w_frameStart ? frame_count_o + 1'b1 : frame_count_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode  <= '0;
         r_solid <= '0;
      end else if (w_frameStart) begin
         r_mode  <= mode_i;
         r_solid <= solid_rgb_i;
      end
   end

   assign w_de    = (r_hc < H_ACT) && (r_vc < V_ACT);
   assign w_hSync = ((r_hc >= H_SS) && (r_hc < H_SE)) ? H_POL : ~H_POL;
   assign w_vSync = ((r_vc >= V_SS) && (r_vc < V_SE)) ? V_POL : ~V_POL;

`ifdef PATTERN_SCROLL_EN
   localparam int SW = CNT_W + FRAME_W;
   logic [SW-1:0] w_sum;
   assign w_sum = SW'(r_hc) + SW'(w_frameNext);
   assign w_x   = CNT_W'(w_sum % SW'(H_ACTIVE));
`else
   assign w_x = r_hc;
`endif

   assign w_barRaw  = w_x / BAR_W;
   assign w_barIdx  = (w_barRaw > BAR_MAX) ? 3'd7 : w_barRaw[2:0];
   assign w_checker = w_x[CHECK_LOG2] ^ r_vc[CHECK_LOG2];
   assign w_gradR   = COLOR_W'({r_hc, {COLOR_W{1'b0}}} / GW'(H_ACTIVE));
   assign w_gradG   = COLOR_W'({r_vc, {COLOR_W{1'b0}}} / GW'(V_ACTIVE));

   // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
   always_comb begin
      w_rgb = '0;
      if (w_de) begin
         case (w_mode)
            2'd0:    w_rgb = w_solid;
            2'd1:    w_rgb = {{COLOR_W{~w_barIdx[1]}}, {COLOR_W{~w_barIdx[2]}}, {COLOR_W{~w_barIdx[0]}}};
            2'd2:    w_rgb = {(3*COLOR_W){w_checker}};
            default: w_rgb = {w_gradR, w_gradG, w_frameNext[COLOR_W-1:0]};
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_count       <= '0;
         v_count       <= '0;
         de_o          <= 1'b0;
         h_sync_in     <= ~H_POL;
         v_sync_in     <= ~V_POL;
         red_port      <= '0;
         green_port    <= '0;
         blue_port     <= '0;
         frame_start_o <= 1'b0;
         frame_count_o <= '0;
      end else begin
         h_count                           <= r_hc;
         v_count                           <= r_vc;
         de_o                              <= w_de;
         h_sync_in                         <= w_hSync;
         v_sync_in                         <= w_vSync;
         {red_port, green_port, blue_port} <= w_rgb;
         frame_start_o                     <= w_frameStart;
         frame_count_o                     <= w_frameNext;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a small-timing instance (22x11 totals) for full-frame behaviour and a
// default 800x600 instance for the first line's timing and colour bars.
module tb_vga_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode_i;
   logic [5:0] solid_rgb_i;

   logic [1:0]  sRed, sGreen, sBlue;
   logic        sHs, sVs, sDe, sFs;
   logic [10:0] sH, sV;
   logic [7:0]  sFc;

   logic [1:0]  dRed, dGreen, dBlue;
   logic        dHs, dVs, dDe, dFs;
   logic [10:0] dH, dV;
   logic [7:0]  dFc;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;

   vga_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(0), .CHECK_LOG2(2)
   ) dutSmall (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .solid_rgb_i(solid_rgb_i),
      .red_port(sRed), .green_port(sGreen), .blue_port(sBlue),
      .h_sync_in(sHs), .v_sync_in(sVs), .de_o(sDe),
      .h_count(sH), .v_count(sV),
      .frame_start_o(sFs), .frame_count_o(sFc)
   );

   vga_pattern_gen dutDefault (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .solid_rgb_i(solid_rgb_i),
      .red_port(dRed), .green_port(dGreen), .blue_port(dBlue),
      .h_sync_in(dHs), .v_sync_in(dVs), .de_o(dDe),
      .h_count(dH), .v_count(dV),
      .frame_start_o(dFs), .frame_count_o(dFc)
   );

   function automatic logic [31:0] smallRgb();
      return 32'({sRed, sGreen, sBlue});
   endfunction

   function automatic logic [31:0] defRgb();
      return 32'({dRed, dGreen, dBlue});
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input logic [5:0] solid);
      mode_i      = mode;
      solid_rgb_i = solid;
   endtask

   task automatic advanceTo(input int target);
      while (cyc < target) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(2'd1, 6'd0);
      repeat (3) @(negedge clk);

      checkOutput("rst s h_count", 32'(sH), 32'd0);
      checkOutput("rst s v_count", 32'(sV), 32'd0);
      checkOutput("rst s de", 32'(sDe), 32'd0);
      checkOutput("rst s frame_start", 32'(sFs), 32'd0);
      checkOutput("rst s frame_count", 32'(sFc), 32'd0);
      checkOutput("rst s rgb", smallRgb(), 32'd0);
      checkOutput("rst s hsync inactive", 32'(sHs), 32'd1);
      checkOutput("rst s vsync inactive", 32'(sVs), 32'd0);
      checkOutput("rst d hsync inactive", 32'(dHs), 32'd0);
      checkOutput("rst d vsync inactive", 32'(dVs), 32'd0);
      checkOutput("rst d de", 32'(dDe), 32'd0);

      rst_n = 1'b1;
      cyc   = -1;
      advanceTo(0);
      checkOutput("s first frame_start", 32'(sFs), 32'd1);
      checkOutput("s first h/v", 32'({sH, sV}), 32'd0);
      checkOutput("s first frame_count", 32'(sFc), 32'd1);
      checkOutput("s first de", 32'(sDe), 32'd1);
      checkOutput("s bar h0 white", smallRgb(), 32'(6'b111111));
      checkOutput("d first frame_start", 32'(dFs), 32'd1);
      checkOutput("d first h/v", 32'({dH, dV}), 32'd0);
      checkOutput("d bar h0 white", defRgb(), 32'(6'b111111));

      advanceTo(1);
      checkOutput("s frame_start one cycle", 32'(sFs), 32'd0);
      checkOutput("d frame_start one cycle", 32'(dFs), 32'd0);
      advanceTo(2);
      checkOutput("s bar h2 yellow", smallRgb(), 32'(6'b111100));
      advanceTo(15);
      checkOutput("s bar h15 black", smallRgb(), 32'd0);
      checkOutput("s de h15", 32'(sDe), 32'd1);
      advanceTo(16);
      checkOutput("s de h16", 32'(sDe), 32'd0);
      advanceTo(17);
      checkOutput("s hsync h17", 32'(sHs), 32'd1);
      advanceTo(18);
      checkOutput("s hsync h18", 32'(sHs), 32'd0);
      advanceTo(19);
      checkOutput("s hsync h19", 32'(sHs), 32'd0);
      advanceTo(20);
      checkOutput("s hsync h20", 32'(sHs), 32'd1);
      advanceTo(100);
      checkOutput("d bar h100 yellow", defRgb(), 32'(6'b111100));
      advanceTo(176);
      checkOutput("s de line8", 32'(sDe), 32'd0);
      checkOutput("s blank rgb line8", smallRgb(), 32'd0);
      advanceTo(197);
      checkOutput("s vsync line8 end", 32'(sVs), 32'd0);
      advanceTo(198);
      checkOutput("s vsync line9 start", 32'(sVs), 32'd1);
      advanceTo(219);
      checkOutput("s vsync line9 end", 32'(sVs), 32'd1);
      advanceTo(220);
      checkOutput("s vsync line10", 32'(sVs), 32'd0);
      advanceTo(242);
      checkOutput("s 2nd frame_start", 32'(sFs), 32'd1);
      checkOutput("s 2nd frame_count", 32'(sFc), 32'd2);

      advanceTo(352);
      applyStimulus(2'd2, 6'd0);
      advanceTo(354);
      checkOutput("s h/v at 354", 32'({sH, sV}), 32'({11'd2, 11'd5}));
      checkOutput("s bars kept mid-frame", smallRgb(), 32'(6'b111100));
      checkOutput("d bar h354 green", defRgb(), 32'(6'b001100));
      advanceTo(484);
      checkOutput("s 3rd frame_start", 32'(sFs), 32'd1);
      checkOutput("s checker (0,0) black", smallRgb(), 32'd0);
      advanceTo(488);
      checkOutput("s checker (4,0) white", smallRgb(), 32'(6'b111111));
      advanceTo(572);
      checkOutput("s checker (0,4) white", smallRgb(), 32'(6'b111111));
      checkOutput("d bar h572 red", defRgb(), 32'(6'b110000));
      advanceTo(576);
      checkOutput("s checker (4,4) black", smallRgb(), 32'd0);

      advanceTo(600);
      applyStimulus(2'd3, 6'd0);
      advanceTo(700);
      checkOutput("d bar h700 black", defRgb(), 32'd0);
      checkOutput("d de h700", 32'(dDe), 32'd1);
      advanceTo(799);
      checkOutput("d de h799", 32'(dDe), 32'd1);
      advanceTo(800);
      checkOutput("d de h800", 32'(dDe), 32'd0);
      checkOutput("d blank rgb h800", defRgb(), 32'd0);
      advanceTo(805);
      checkOutput("s gradient (13,3)", smallRgb(), 32'(6'b110100));
      advanceTo(845);
      checkOutput("s h/v at 845", 32'({sH, sV}), 32'({11'd9, 11'd5}));
      checkOutput("s gradient (9,5)", smallRgb(), 32'(6'b101000));
      advanceTo(855);
      checkOutput("d hsync h855", 32'(dHs), 32'd0);
      advanceTo(856);
      checkOutput("d hsync h856", 32'(dHs), 32'd1);

      advanceTo(900);
      applyStimulus(2'd0, 6'b100111);
      advanceTo(975);
      checkOutput("d hsync h975", 32'(dHs), 32'd1);
      advanceTo(976);
      checkOutput("d hsync h976", 32'(dHs), 32'd0);
      checkOutput("d vsync line0", 32'(dVs), 32'd0);
      advanceTo(985);
      checkOutput("s solid blank h17", smallRgb(), 32'd0);
      advanceTo(1015);
      checkOutput("s solid (3,2)", smallRgb(), 32'(6'b100111));
      applyStimulus(2'd0, 6'b111111);
      advanceTo(1039);
      checkOutput("s solid kept mid-frame", smallRgb(), 32'(6'b100111));

      #1 rst_n = 1'b0;
      #1;
      checkOutput("async rst s h/v", 32'({sH, sV}), 32'd0);
      checkOutput("async rst s rgb", smallRgb(), 32'd0);
      checkOutput("async rst s hsync", 32'(sHs), 32'd1);
      checkOutput("async rst s frame_count", 32'(sFc), 32'd0);
      checkOutput("async rst d h_count", 32'(dH), 32'd0);
      checkOutput("async rst d frame_count", 32'(dFc), 32'd0);

      repeat (2) @(negedge clk);
      applyStimulus(2'd3, 6'd0);
      rst_n = 1'b1;
      cyc   = -1;
      advanceTo(0);
      checkOutput("restart s frame_start", 32'(sFs), 32'd1);
      checkOutput("restart s h/v", 32'({sH, sV}), 32'd0);
      checkOutput("restart s frame_count", 32'(sFc), 32'd1);
      checkOutput("restart s gradient blue", smallRgb(), 32'd1);
      checkOutput("restart d frame_start", 32'(dFs), 32'd1);

      advanceTo(242 * 254);
      checkOutput("wrap s frame_start 255", 32'(sFs), 32'd1);
      checkOutput("wrap s frame_count 255", 32'(sFc), 32'd255);
      checkOutput("wrap s gradient blue 3", smallRgb(), 32'd3);
      advanceTo(242 * 255);
      checkOutput("wrap s frame_start 0", 32'(sFs), 32'd1);
      checkOutput("wrap s frame_count 0", 32'(sFc), 32'd0);
      checkOutput("wrap s gradient blue 0", smallRgb(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator; successor to the fixed 800x600 2-bit-per-channel tester block.
- Generates h_sync/v_sync/data-enable and per-pixel RGB for any timing set.
- Selectable pattern modes (solid, colour bars, checkerboard, gradient), switched glitch-free at frame boundaries.
- Drives the board VGA DAC pins directly.
- Also the reference stimulus for the future frame-buffer path.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_SYNC_POL, 1, active level of h_sync
V_SYNC_POL, 1, active level of v_sync
CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
COLOR_W, 2, bits per colour channel
CHECK_LOG2, 5, checkerboard cell size = 2**CHECK_LOG2 pixels
FRAME_W, 8, frame counter width

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
mode_i  input  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient
solid_rgb_i  input  3*COLOR_W  solid colour {R,G,B} for mode 0
red_port  output  COLOR_W  red channel
green_port  output  COLOR_W  green channel
blue_port  output  COLOR_W  blue channel
h_sync_in  output  1  horizontal sync to connector
v_sync_in  output  1  vertical sync to connector
de_o  output  1  active-video flag
h_count  output  CNT_W  pixel column of current outputs
v_count  output  CNT_W  line of current outputs
frame_start_o  output  1  one-cycle pulse at pixel (0,0)
frame_count_o  output  FRAME_W  completed-frame counter

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL likewise (default 666).
- Internal counters hc, vc:
  - hc increments every clk and wraps at H_TOTAL-1 to 0.
  - vc increments when hc wraps, and wraps at V_TOTAL-1 to 0.
- Output stage: all outputs are registered together from hc/vc, giving 1-cycle latency. h_count/v_count, syncs, de_o and RGB are always mutually aligned.
- de_o = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- h_sync_in = H_SYNC_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC; otherwise the inverse level.
- v_sync_in uses the same rule on v_count with the V_* parameters. It changes only on the cycle where h_count becomes 0.
- RGB is forced to 0 whenever de_o=0.
- Mode and solid colour are latched into shadow registers when hc=0 and vc=0, so a change mid-frame takes effect at the next frame start.
- Patterns, full-scale FS = all ones:
  - Mode 0: {R,G,B} = latched solid_rgb_i.
  - Mode 1: bar index = h_count / (H_ACTIVE/8), clamped to 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black; each channel is either FS or 0.
  - Mode 2: white when h_count[CHECK_LOG2] XOR v_count[CHECK_LOG2], else black.
  - Mode 3:
    - R = top COLOR_W bits of h_count scaled over H_ACTIVE, i.e. (h_count*2**COLOR_W)/H_ACTIVE.
    - G = the same scaling of v_count over V_ACTIVE.
    - B = frame_count_o[COLOR_W-1:0].
- frame_start_o is high for exactly the cycle where h_count=0 and v_count=0.
- frame_count_o increments on that same cycle and wraps at 2**FRAME_W.
- Reset values:
  - hc, vc, h_count, v_count, frame_count_o = 0.
  - RGB = 0, de_o = 0, frame_start_o = 0.
  - Syncs at their inactive level.
  - Shadow mode = 0, shadow colour = 0.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The first output after release is pixel (0,0) with frame_start_o=1, one clk after the first counting edge.

Optional Feature:
PATTERN_SCROLL_EN
- With the macro defined: modes 1 and 2 use x = (h_count + frame_count_o) mod H_ACTIVE in place of h_count, so the pattern scrolls left one pixel per frame. Latency and sync timing are unchanged.
- Without the macro: x = h_count, static patterns, and no adder is synthesised.

Test Plan:
- Reset with defaults, rst_n low 3 cycles: all outputs at reset values, syncs at the inactive level 0. After release, frame_start_o pulses with h_count=0/v_count=0. Consecutive pulses are 692640 cycles apart.
- Default timing:
  - de_o high for h_count 0..799 on lines 0..599.
  - h_sync_in high exactly for h_count 856..975 (120 cycles).
  - v_sync_in high for lines 637..642.
  - RGB = 0 in every blanking cycle.
- Mode 1, COLOR_W=2:
  - h_count=0 gives RGB 3/3/3; h_count=100 gives 3/3/0; h_count=700..799 gives 0/0/0.
  - Setting mode_i=2 at line 300 leaves the bars unchanged until the next frame_start_o, which shows checkerboard.
- Small params (H 16/2/2/2, V 8/1/1/1, CHECK_LOG2=2, H_SYNC_POL=0):
  - Checker is white at (4,0) and black at (4,4).
  - h_sync_in is low only at h_count 18..19.
  - frame_count_o wraps 255 to 0 after 256 frames (FRAME_W=8).
- rst_n asserted at h_count=400, v_count=200: outputs clear within the same cycle with no clk edge. After release, timing restarts from (0,0).
- With PATTERN_SCROLL_EN, mode 1, frame_count_o=100: h_count=0 shows yellow and h_count=700 shows white.
